// File: rtl/unidade_controle_if.sv
// unidade_controle_if: keys, instruction/ALU inputs and register-bank/ALU outputs of the controller
interface unidade_controle_if;
  logic        exec_n;
  logic        view_n;
  logic [15:0] instr;
  logic [15:0] alu_result;
  logic [4:0]  reg_a;
  logic [4:0]  reg_b;
  logic [4:0]  reg_c;
  logic [4:0]  codop;
  logic [15:0] imm;
  logic        bank_we;
  logic [15:0] wb_data;
  logic        busy;
  logic        illegal;
  modport master (
    input  exec_n, view_n, instr, alu_result,
    output reg_a, reg_b, reg_c, codop, imm, bank_we, wb_data, busy, illegal
  );
  modport slave (
    output exec_n, view_n, instr, alu_result,
    input  reg_a, reg_b, reg_c, codop, imm, bank_we, wb_data, busy, illegal
  );
endinterface

// File: rtl/unidade_controle.sv
// unidade_controle: debounced pushbutton controller that decodes a switch instruction,
// drives register-bank addresses and ALU operands, and writes the ALU result back once per press.
module unidade_controle #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ALU_LATENCY     = 1
) (
  input logic                CLOCK_50,
  input logic                reset_n,
  unidade_controle_if.master bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WRITE, HOLD} state_t;
  state_t        r_state, w_next;
  logic [1:0]    w_key, r_s1, r_s2, r_rel, r_ev;
  logic [CW-1:0] r_cnt [2];
  logic [15:0]   r_instr, r_imm, r_wb;
  logic [3:0]    r_a, r_b, r_c, r_op;
  logic [2:0]    r_lat;
  logic          r_ill;
  logic          w_ex_done;
  assign w_key     = {bus.view_n, bus.exec_n};
  assign w_ex_done = r_lat == 3'(ALU_LATENCY - 1);
  // r_rel starts low so a key held through reset must be seen released before a press counts
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      r_s1  <= '1;
      r_s2  <= '1;
      r_rel <= '0;
      r_ev  <= '0;
      for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
    end else begin
      r_s1 <= w_key;
      r_s2 <= r_s1;
      r_ev <= '0;
      for (int k = 0; k < 2; k++)
        if (r_s2[k] == r_rel[k]) r_cnt[k] <= '0;
        else if (r_cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_cnt[k] <= '0;
          r_rel[k] <= r_s2[k];
          r_ev[k]  <= !r_s2[k];
        end else r_cnt[k] <= r_cnt[k] + CW'(1);
    end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = r_ev[0] ? DECODE : IDLE;
      DECODE:  w_next = r_instr[15:12] > 4'd10 ? HOLD : EXEC;
      EXEC:    w_next = w_ex_done ? WRITE : EXEC;
      WRITE:   w_next = HOLD;
      HOLD:    w_next = r_rel[0] ? IDLE : HOLD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      r_instr <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_op    <= '0;
      r_imm   <= '0;
      r_wb    <= '0;
      r_lat   <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_lat <= r_state == EXEC ? r_lat + 3'd1 : 3'd0;
      case (r_state)
        IDLE:
          if (r_ev[0]) begin
            r_instr <= bus.instr;
            if (bus.instr[15:12] <= 4'd10) r_ill <= 1'b0;
          end else if (r_ev[1]) begin
            r_a <= bus.instr[11:8];
            r_b <= bus.instr[7:4];
          end
        DECODE: begin
          r_op <= r_instr[15:12];
          if (r_instr[15:12] <= 4'd5) begin
            r_c <= r_instr[11:8];
            r_a <= r_instr[7:4];
            r_b <= r_instr[3:0];
          end else if (r_instr[15:12] <= 4'd10) begin
            r_c   <= r_instr[11:8];
            r_imm <= {12'd0, r_instr[7:4]};
            r_b   <= r_instr[3:0];
            r_a   <= '0;
          end else r_ill <= 1'b1;
        end
        EXEC: if (w_ex_done) r_wb <= bus.alu_result;
        default: ;
      endcase
    end
  assign bus.reg_a   = {1'b0, r_a};
  assign bus.reg_b   = {1'b0, r_b};
  assign bus.reg_c   = {1'b0, r_c};
  assign bus.codop   = {1'b0, r_op};
  assign bus.imm     = r_imm;
  assign bus.wb_data = r_wb;
  assign bus.bank_we = r_state == WRITE;
  assign bus.busy    = r_state != IDLE;
  assign bus.illegal = r_ill;
endmodule

// File: doc/unidade_controle.md
UNIDADE_CONTROLE -- requirements
Module: unidade_controle

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: a key SHALL hold one level for this many consecutive clocks before the level is accepted.
REQ-003 Parameter ALU_LATENCY, default 1: clocks from operand issue to a valid alu_result, range 1-7.
REQ-004 Port CLOCK_50, input, 1 bit: system clock.
REQ-005 Port reset_n, input, 1 bit: asynchronous reset, active low.
REQ-006 Port exec_n, input, 1 bit: execute pushbutton, active low, asynchronous to the clock.
REQ-007 Port view_n, input, 1 bit: view pushbutton, active low, asynchronous to the clock.
REQ-008 Port instr, input, 16 bits: instruction from the switches, as [15:12] codop, [11:8] f1, [7:4] f2, [3:0] f3.
REQ-009 Port alu_result, input, 16 bits: result from the ALU.
REQ-010 Ports reg_a, reg_b and reg_c, outputs, 5 bits each: register bank addresses for source A, source B and destination.
REQ-011 Port codop, output, 5 bits: opcode sent to the ALU.
REQ-012 Port imm, output, 16 bits: immediate operand sent to the ALU.
REQ-013 Port bank_we, output, 1 bit: register bank write strobe, active high.
REQ-014 Port wb_data, output, 16 bits: data written to the register bank.
REQ-015 Port busy, output, 1 bit: high while the state is not IDLE.
REQ-016 Port illegal, output, 1 bit: sticky flag for an undefined opcode.

Function
REQ-017 Each key input SHALL pass through a two-flop synchronizer and then a debounce counter, giving at most one press event per physical press.
- The counter re-arms only after the key reads high for DEBOUNCE_CYCLES.
REQ-018 The FSM SHALL have exactly five states: IDLE, DECODE, EXEC, WRITE and HOLD.
REQ-019 IDLE, exec press event in cycle T: the FSM SHALL enter DECODE at T+1 and capture instr at that edge.
REQ-020 IDLE, view press event only:
- load reg_a = {0,instr[11:8]} and reg_b = {0,instr[7:4]};
- no write;
- remain in IDLE.
REQ-021 If exec and view press events occur in the same cycle, exec SHALL take priority and the view event SHALL be discarded.
REQ-022 DECODE SHALL set codop = {0,instr[15:12]} and then move to EXEC on the next clock.
REQ-023 Decoding for codop 0-5 (register type):
- reg_c = f1, reg_a = f2, reg_b = f3;
- imm unchanged.
REQ-024 Decoding for codop 6-10 (immediate type):
- reg_c = f1, imm = {12'd0,f2}, reg_b = f3;
- reg_a = 0.
REQ-025 For codop 11-15, DECODE SHALL set illegal=1 and go directly to HOLD with no write.
- illegal clears at the next legal exec capture.
REQ-026 EXEC SHALL wait exactly ALU_LATENCY clocks, holding all address, codop and imm outputs stable.
REQ-027 WRITE SHALL last exactly one clock, with bank_we=1 and wb_data equal to alu_result sampled on entry.
- The FSM then moves to HOLD.
REQ-028 HOLD SHALL return to IDLE only once exec_n is debounced high, so a held key never runs an instruction twice.
REQ-029 Any key event outside IDLE SHALL be ignored and not queued.
REQ-030 bank_we SHALL be high only in WRITE.
REQ-031 Register addresses SHALL have bit 4 at 0 at all times.

Reset
REQ-032 While reset_n=0, outputs SHALL immediately take these values, regardless of the clock:
- state IDLE;
- reg_a, reg_b, reg_c, codop, imm and wb_data = 0;
- bank_we, busy and illegal = 0;
- debounce counters cleared, with keys treated as released.
REQ-033 Reset asserted mid-instruction SHALL abort it with no write, including during WRITE, where bank_we drops without waiting for the clock.
REQ-034 After reset_n deasserts, a key already held low SHALL be accepted only after it has been released and pressed again.

Verification
REQ-035 Register-type exec (DEBOUNCE_CYCLES=4, ALU_LATENCY=1), instr=16'h0123 with exec_n pressed cleanly; check:
- codop=0, reg_c=1, reg_a=2, reg_b=3;
- a single bank_we pulse with wb_data equal to alu_result, 3 clocks after capture.
REQ-036 Immediate-type exec, instr=16'h6A5C; check:
- reg_c=10, imm=16'h0005, reg_b=12, reg_a=0;
- one bank_we pulse.
REQ-037 Illegal opcode exec, instr=16'hF000; check illegal=1 with no bank_we. A following exec of 16'h1123 clears illegal and writes.
REQ-038 Bounce: exec_n toggles every 2 clocks for 20 clocks, then holds low for 200 clocks; check exactly one write and busy staying high until release.
REQ-039 Simultaneous events: view and exec pressed in the same cycle; check an execute sequence only. Separately, view with instr=16'h0450; check reg_a=4, reg_b=5 and no write.
REQ-040 Reset mid-operation: reset_n pulsed low during EXEC, and separately during WRITE; check bank_we=0 immediately, all outputs 0, and no further write until a new press.
